// File: rtl/wb_pipe_decoder.sv
// Pipelined Wishbone B4 decoder: one master to NS slaves, in-order tag FIFO for
// response routing, internal error responder for unmapped addresses and a response watchdog.
module wb_pipe_decoder #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int NS      = 5,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255,
  parameter logic [NS*AW-1:0] SLV_BASE = {16'h7000, 16'h6000, 16'h5000, 16'h4000, 16'h0000},
  parameter logic [NS*AW-1:0] SLV_MASK = {16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hC000}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_cyc,
  input  logic             m_stb,
  input  logic             m_we,
  input  logic [AW-1:0]    m_adr,
  input  logic [DW-1:0]    m_dat_o,
  output logic [DW-1:0]    m_dat_i,
  output logic             m_ack,
  output logic             m_err,
  output logic             m_stall,
  output logic [NS-1:0]    s_cyc,
  output logic [NS-1:0]    s_stb,
  output logic             s_we,
  output logic [AW-1:0]    s_adr,
  output logic [DW-1:0]    s_dat_i,
  input  logic [NS*DW-1:0] s_dat_o,
  input  logic [NS-1:0]    s_ack,
  input  logic [NS-1:0]    s_stall
);

  localparam int TW  = $clog2(NS + 1);
  localparam int PW  = $clog2(MAX_OUT);
  localparam int CW  = PW + 1;
  localparam int TMW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] ERR_TAG = TW'(NS);

  logic [TW-1:0]  fifo_q [MAX_OUT];
  logic [TW-1:0]  fifo_d [MAX_OUT];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [TMW-1:0] timer_q, timer_d;
  logic [TW-1:0]  last_tag_q, last_tag_d;
  logic           abort_q, abort_d;

  logic [TW-1:0] target, head_tag;
  logic          tgt_s_stall, stall_int, issue, busy;
  logic          head_ack, resp_ok, ack, err_resp, pop, timeout, flush;
  logic [DW-1:0] head_dat;

  // Lowest index wins on overlapping windows, so scan from the top down.
  always_comb begin
    target      = ERR_TAG;
    tgt_s_stall = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((m_adr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) target = TW'(i);
    end
    for (int i = 0; i < NS; i++) begin
      if (target == TW'(i)) tgt_s_stall = s_stall[i];
    end
  end

  assign head_tag = fifo_q[rd_ptr_q];
  assign busy     = (count_q != '0);

  always_comb begin
    head_ack = 1'b0;
    head_dat = '0;
    for (int i = 0; i < NS; i++) begin
      if (head_tag == TW'(i)) begin
        head_ack = s_ack[i];
        head_dat = s_dat_o[i*DW +: DW];
      end
    end
  end

  // Handshake: a request transfers when m_cyc & m_stb & !m_stall; a response
  // is consumed by the master in the single cycle m_ack or m_err is high.
  // Switching slaves waits for the FIFO to drain so responses stay in order.
  assign stall_int = (count_q == CW'(MAX_OUT)) | (busy & (target != last_tag_q)) | tgt_s_stall;
  assign issue     = m_cyc & m_stb & ~stall_int;

  assign resp_ok  = busy & m_cyc & ~abort_q;
  assign ack      = resp_ok & head_ack;
  assign err_resp = resp_ok & (head_tag == ERR_TAG);
  assign pop      = ack | err_resp;
  assign timeout  = resp_ok & ~pop & (timer_q == TMW'(TIMEOUT - 1));
  assign flush    = ~m_cyc | timeout;

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    timer_d    = timer_q;
    last_tag_d = last_tag_q;
    abort_d    = timeout;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      timer_d  = '0;
    end else begin
      if (issue) begin
        fifo_d[wr_ptr_q] = target;
        wr_ptr_d         = wr_ptr_q + 1'b1;
        last_tag_d       = target;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(issue) - CW'(pop);
      timer_d = (pop | ~busy) ? '0 : timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUT; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      last_tag_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      last_tag_q <= last_tag_d;
      abort_q    <= abort_d;
    end
  end

  // Outputs are gated by rst_n so the bus goes quiet as soon as reset asserts.
  assign m_ack   = rst_n & ack;
  assign m_err   = rst_n & (err_resp | timeout);
  assign m_dat_i = (rst_n & ack) ? head_dat : '0;
  assign m_stall = rst_n ? stall_int : tgt_s_stall;

  always_comb begin
    s_cyc = '0;
    s_stb = '0;
    for (int i = 0; i < NS; i++) begin
      s_stb[i] = rst_n & m_cyc & m_stb & (target == TW'(i)) & ~stall_int;
      s_cyc[i] = rst_n & m_cyc & ~abort_q &
                 ((m_stb & (target == TW'(i))) | (busy & (head_tag == TW'(i))));
    end
  end

  assign s_we    = m_we;
  assign s_adr   = m_adr;
  assign s_dat_i = m_dat_o;

endmodule

// File: tb/tb_wb_pipe_decoder.sv
// Bench for wb_pipe_decoder: behavioural slaves with programmable ack delay,
// scoreboard of expected master responses, directed scenarios for each feature.
module tb_wb_pipe_decoder;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NS = 5;
  localparam int W  = DW + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [AW-1:0]    m_adr = '0;
  logic [DW-1:0]    m_dat_o = '0;
  logic [DW-1:0]    m_dat_i;
  logic             m_ack, m_err, m_stall;
  logic [NS-1:0]    s_cyc, s_stb;
  logic             s_we;
  logic [AW-1:0]    s_adr;
  logic [DW-1:0]    s_dat_i;
  logic [NS*DW-1:0] s_dat_o = '0;
  logic [NS-1:0]    s_ack;
  logic [NS-1:0]    s_stall = '0;
  logic [NS-1:0]    mdl_ack = '0;
  logic [NS-1:0]    force_ack = '0;

  assign s_ack = mdl_ack | force_ack;

  always #5 clk = ~clk;

  wb_pipe_decoder #(.AW(AW), .DW(DW), .NS(NS), .MAX_OUT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_o(m_dat_o),
    .m_dat_i(m_dat_i), .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_i(s_dat_i),
    .s_dat_o(s_dat_o), .s_ack(s_ack), .s_stall(s_stall)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent model of the address map.
  function automatic int exp_tag(input logic [15:0] a);
    if ((a & 16'hC000) == 16'h0000) return 0;
    case (a[15:12])
      4'h4: return 1;
      4'h5: return 2;
      4'h6: return 3;
      4'h7: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic logic [15:0] slv_data(input int i, input logic [15:0] a, input logic we);
    if (we) return 16'h0000;
    return 16'hA0A0 + 16'(i * 256) + {12'h000, a[3:0]};
  endfunction

  // ---------------- slave models ----------------
  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] due;
    logic [15:0] dat;
  } pend_t;
  pend_t       pend_q[$];
  int unsigned cyc_n = 0;
  int          dly[NS];

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (mdl_ack[i]) begin
        for (int k = 0; k < pend_q.size(); k++) begin
          if (pend_q[k].idx == 3'(i)) begin
            pend_q.delete(k);
            break;
          end
        end
      end
      if (!s_cyc[i]) begin
        for (int k = pend_q.size() - 1; k >= 0; k--) begin
          if (pend_q[k].idx == 3'(i)) pend_q.delete(k);
        end
      end else if (s_stb[i] && !s_stall[i]) begin
        pend_q.push_back('{idx: 3'(i), due: 32'(cyc_n + 32'(dly[i])), dat: slv_data(i, s_adr, s_we)});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc_n++;
    for (int i = 0; i < NS; i++) begin
      mdl_ack[i] = 1'b0;
      s_dat_o[i*DW +: DW] = '0;
      for (int k = 0; k < pend_q.size(); k++) begin
        if (pend_q[k].idx == 3'(i)) begin
          if (pend_q[k].due <= cyc_n) begin
            mdl_ack[i] = 1'b1;
            s_dat_o[i*DW +: DW] = pend_q[k].dat;
          end
          break;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (rst_n && (m_ack || m_err)) begin
      if (exp_q.size() == 0) check_eq("unexpected_resp", {m_ack, m_err, m_dat_i}, 0);
      else check_eq("resp", {m_ack, m_err, m_dat_i}, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [15:0] adr, input logic we, input logic to_err,
                       output int nst, output logic [NS-1:0] stb_v, output logic [NS-1:0] cyc_v);
    int t;
    logic [DW-1:0] wd;
    wd = DW'($urandom_range(0, 65535));
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = adr; m_we = we; m_dat_o = wd;
    nst = 0;
    forever begin
      @(negedge clk);
      if (!m_stall) break;
      nst++;
      if (nst > 100) break;
    end
    stb_v = s_stb;
    cyc_v = s_cyc;
    if (nst > 100) check_eq("stall_bound", 64'(nst), 64'(100));
    else begin
      check_eq("s_adr", s_adr, adr);
      check_eq("s_we", s_we, we);
      check_eq("s_dat_i", s_dat_i, wd);
      t = exp_tag(adr);
      if (to_err || t == NS) exp_q.push_back({2'b01, 16'h0000});
      else exp_q.push_back({2'b10, slv_data(t, adr, we)});
    end
    @(posedge clk); #1;
    m_stb = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_drained"}, 64'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int nst, n;
    logic [NS-1:0] sv, cv;
    int exp_nst[6];
    exp_nst = '{0, 0, 0, 0, 3, 0};
    for (int i = 0; i < NS; i++) dly[i] = 2;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outs", {m_ack, m_err, m_dat_i, s_cyc, s_stb, m_stall}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_outs", {m_ack, m_err, m_dat_i, s_cyc, s_stb, m_stall}, 0);

    // back-to-back reads to slave 0
    for (int k = 0; k < 3; k++) begin
      drive(16'h0010 + 16'(k), 1'b0, 1'b0, nst, sv, cv);
      check_eq("b2b_nstall", 64'(nst), 0);
      check_eq("b2b_stb", sv, 5'b00001);
    end
    drain("b2b");
    m_adr = 16'h6000;
    #1 check_eq("b2b_idle_stall", m_stall, 1'b0);

    // slave switch held until the FIFO drains
    drive(16'h0000, 1'b0, 1'b0, nst, sv, cv);
    drive(16'h5000, 1'b0, 1'b0, nst, sv, cv);
    check_eq("switch_nstall", 64'(nst), 2);
    check_eq("switch_stb", sv, 5'b00100);
    drain("switch");

    // unmapped address
    drive(16'h8000, 1'b0, 1'b0, nst, sv, cv);
    check_eq("unmap_stb", sv, 0);
    check_eq("unmap_cyc", cv, 0);
    @(negedge clk);
    check_eq("unmap_err", {m_ack, m_err}, 2'b01);
    @(negedge clk);
    check_eq("unmap_err_once", m_err, 1'b0);
    drain("unmap");

    // watchdog on a slave that never acks
    dly[1] = 1000;
    drive(16'h4000, 1'b1, 1'b1, nst, sv, cv);
    n = 1;
    forever begin
      @(negedge clk);
      if (m_err || n > 50) break;
      n++;
    end
    check_eq("wdog_latency", 64'(n), 8);
    check_eq("wdog_cyc_before", s_cyc[1], 1'b1);
    @(negedge clk);
    check_eq("wdog_abort_cyc", s_cyc[1], 1'b0);
    @(posedge clk); #1;
    force_ack = 5'b00010;
    @(negedge clk);
    check_eq("late_ack", {m_ack, m_err}, 2'b00);
    @(posedge clk); #1;
    force_ack = '0;
    dly[1] = 2;
    drain("wdog");

    // outstanding limit
    dly[0] = 6;
    for (int k = 0; k < 6; k++) begin
      drive(16'h0000 + 16'(k), 1'b0, 1'b0, nst, sv, cv);
      check_eq("maxout_nstall", 64'(nst), 64'(exp_nst[k]));
    end
    drain("maxout");

    // reset with transfers in flight
    for (int k = 0; k < 3; k++) drive(16'h0000 + 16'(k), 1'b0, 1'b0, nst, sv, cv);
    rst_n = 1'b0;
    #1 check_eq("midrst_outs", {m_ack, m_err, m_dat_i, s_cyc, s_stb}, 0);
    s_stall = 5'b00001;
    #1 check_eq("rst_stall_pass", m_stall, 1'b1);
    s_stall = '0;
    #1 check_eq("rst_stall_clr", m_stall, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    dly[3] = 1;
    drive(16'h6000, 1'b0, 1'b0, nst, sv, cv);
    check_eq("post_rst_stb", sv, 5'b01000);
    drain("post_rst");
    repeat (8) @(posedge clk);
    m_cyc = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
